// File: rtl/hera_boot_loader.sv
// rtl/hera_boot_loader.sv - framed byte-stream loader for HERA instruction memory
// Purpose : assembles MAGIC/LEN/DATA/CSUM frames into WORD_W-bit words, writes
//           them to instruction memory, verifies an 8-bit checksum and releases
//           the CPU only after a good load.
// Ports   : clk, hard_rst (async, active-high)
//           in_data/in_valid/in_ready : received byte stream (never stalled)
//           wr_en/wr_addr/wr_data     : instruction memory write port
//           cpu_run                   : CPU owns memory and is out of reset
//           busy                      : frame in progress
//           err/err_code              : last frame failed and why (1 csum, 2 len, 3 timeout)
module hera_boot_loader #(
  parameter int          WORD_W  = 16,
  parameter int          ADDR_W  = 10,
  parameter int          TIMEOUT = 48000,
  parameter logic [7:0]  MAGIC   = 8'hA5
) (
  input  logic              clk,
  input  logic              hard_rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              cpu_run,
  output logic              busy,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam int BPW    = WORD_W / 8;
  localparam int BIDX_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int TMO_W  = $clog2(TIMEOUT + 1);
  localparam logic [16:0]       DEPTH     = 17'(2 ** ADDR_W);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);
  localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(BPW - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM, S_RUN, S_ERR
  } state_t;

  state_t              state_q, state_d;
  logic [15:0]         len_q, len_d;
  logic [7:0]          sum_q, sum_d;
  logic [15:0]         ptr_q, ptr_d;
  logic [WORD_W-1:0]   asm_q, asm_d;
  logic [BIDX_W-1:0]   bidx_q, bidx_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [WORD_W-1:0]   wr_data_q, wr_data_d;
  logic [1:0]          err_code_q, err_code_d;

  logic              acc, is_magic, in_frame, tmo_hit;
  logic [15:0]       len_full;
  logic              len_bad, len_zero, last_byte, last_word, sum_ok;
  logic [7:0]        sum_add;
  logic [WORD_W-1:0] word_next;

  // Bytes are never stalled, so every valid byte is accepted.
  assign acc       = in_valid;
  assign is_magic  = acc && (in_data == MAGIC);
  assign in_frame  = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                     (state_q == S_DATA)   || (state_q == S_CSUM);
  // A byte on the expiry cycle wins over the timeout.
  assign tmo_hit   = in_frame && !acc && (tmo_q == TMO_LAST);
  assign len_full  = {len_q[15:8], in_data};
  assign len_bad   = {1'b0, len_full} > DEPTH;
  assign len_zero  = (len_full == 16'd0);
  assign last_byte = (bidx_q == BIDX_LAST);
  assign last_word = ({1'b0, ptr_q} + 17'd1) == {1'b0, len_q};
  assign sum_add   = sum_q + in_data;
  assign sum_ok    = (sum_add == 8'd0);
  assign word_next = (asm_q << 8) | WORD_W'(in_data);

  // State register
  always_ff @(posedge clk or posedge hard_rst) begin
    if (hard_rst) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (tmo_hit) begin
      state_d = S_ERR;
    end else if (acc) begin
      case (state_q)
        S_IDLE, S_RUN, S_ERR: if (is_magic) state_d = S_LEN_HI;
        S_LEN_HI: state_d = S_LEN_LO;
        S_LEN_LO: begin
          if (len_bad)       state_d = S_ERR;
          else if (len_zero) state_d = S_CSUM;
          else               state_d = S_DATA;
        end
        S_DATA:  if (last_byte && last_word) state_d = S_CSUM;
        S_CSUM:  state_d = sum_ok ? S_RUN : S_ERR;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs decoded from state
  always_comb begin
    in_ready = 1'b1;
    cpu_run  = (state_q == S_RUN);
    busy     = in_frame;
    err      = (state_q == S_ERR);
    wr_en    = wr_en_q;
    wr_addr  = wr_addr_q;
    wr_data  = wr_data_q;
    err_code = err_code_q;
  end

  // Datapath next-state: length, checksum, word assembly, write port, timeout
  always_comb begin
    len_d      = len_q;
    sum_d      = sum_q;
    ptr_d      = ptr_q;
    asm_d      = asm_q;
    bidx_d     = bidx_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    err_code_d = err_code_q;
    tmo_d      = (acc || !in_frame || tmo_hit) ? '0 : tmo_q + TMO_W'(1);

    if (tmo_hit) begin
      err_code_d = 2'd3;
    end else if (acc) begin
      case (state_q)
        S_IDLE, S_RUN, S_ERR: begin
          if (is_magic) begin
            err_code_d = 2'd0;
            sum_d      = 8'd0;
            ptr_d      = 16'd0;
            asm_d      = '0;
            bidx_d     = '0;
          end
        end
        S_LEN_HI: begin
          len_d[15:8] = in_data;
          sum_d       = sum_add;
        end
        S_LEN_LO: begin
          len_d[7:0] = in_data;
          sum_d      = sum_add;
          if (len_bad) err_code_d = 2'd2;
        end
        S_DATA: begin
          sum_d = sum_add;
          if (last_byte) begin
            asm_d     = '0;
            bidx_d    = '0;
            wr_en_d   = 1'b1;
            wr_data_d = word_next;
            wr_addr_d = ptr_q[ADDR_W-1:0];
            ptr_d     = ptr_q + 16'd1;
          end else begin
            asm_d  = word_next;
            bidx_d = bidx_q + BIDX_W'(1);
          end
        end
        S_CSUM: begin
          sum_d = sum_add;
          if (!sum_ok) err_code_d = 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge hard_rst) begin
    if (hard_rst) begin
      len_q      <= '0;
      sum_q      <= '0;
      ptr_q      <= '0;
      asm_q      <= '0;
      bidx_q     <= '0;
      tmo_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      err_code_q <= 2'd0;
    end else begin
      len_q      <= len_d;
      sum_q      <= sum_d;
      ptr_q      <= ptr_d;
      asm_q      <= asm_d;
      bidx_q     <= bidx_d;
      tmo_q      <= tmo_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      err_code_q <= err_code_d;
    end
  end

endmodule

// File: tb/tb_hera_boot_loader.sv
// tb/tb_hera_boot_loader.sv - directed self-checking bench for hera_boot_loader
module tb_hera_boot_loader;

  logic        clk = 1'b0;
  logic        hard_rst = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready, wr_en, cpu_run, busy, err;
  logic [9:0]  wr_addr;
  logic [15:0] wr_data;
  logic [1:0]  err_code;

  int total = 0;
  int bad = 0;

  logic [9:0]  wa[$];
  logic [15:0] wd[$];

  hera_boot_loader #(.WORD_W(16), .ADDR_W(10), .TIMEOUT(16), .MAGIC(8'hA5)) dut (
    .clk(clk), .hard_rst(hard_rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_run(cpu_run), .busy(busy), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  // Record every memory write away from the active edge.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      wa.push_back(wr_addr);
      wd.push_back(wr_data);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic clear_writes();
    wa.delete();
    wd.delete();
  endtask

  task automatic check_two_good_writes(input string tag);
    total++;
    if (wa.size() !== 2) begin
      bad++; $display("FAIL %s_write_count got=%0d want=2", tag, wa.size());
    end else begin
      total++;
      if (wa[0] !== 10'h000 || wd[0] !== 16'h1234) begin
        bad++; $display("FAIL %s_write0 got=(%h,%h) want=(000,1234)", tag, wa[0], wd[0]);
      end
      total++;
      if (wa[1] !== 10'h001 || wd[1] !== 16'hABCD) begin
        bad++; $display("FAIL %s_write1 got=(%h,%h) want=(001,abcd)", tag, wa[1], wd[1]);
      end
    end
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({in_ready, wr_en, wr_addr, wr_data, cpu_run, busy, err, err_code} !==
        {1'b1, 1'b0, 10'h0, 16'h0, 1'b0, 1'b0, 1'b0, 2'd0}) begin
      bad++; $display("FAIL reset_outputs got rdy=%b we=%b a=%h d=%h run=%b busy=%b err=%b code=%0d",
                      in_ready, wr_en, wr_addr, wr_data, cpu_run, busy, err, err_code);
    end
    @(negedge clk);
    hard_rst = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if ({busy, cpu_run, err} !== 3'b000) begin
      bad++; $display("FAIL reset_release got busy=%b run=%b err=%b want 000", busy, cpu_run, err);
    end
    send_byte(8'h33);
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL idle_discard got busy=%b want=0", busy);
    end
  endtask

  task automatic test_good_load();
    logic [7:0] f [0:6];
    f = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    clear_writes();
    for (int i = 0; i < 7; i++) send_byte(f[i]);
    total++;
    if (busy !== 1'b1 || cpu_run !== 1'b0) begin
      bad++; $display("FAIL good_pre_csum got busy=%b run=%b want busy=1 run=0", busy, cpu_run);
    end
    send_byte(8'h40);
    total++;
    if (cpu_run !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL good_run got run=%b busy=%b want run=1 busy=0", cpu_run, busy);
    end
    total++;
    if (err !== 1'b0 || err_code !== 2'd0) begin
      bad++; $display("FAIL good_err got err=%b code=%0d want 0/0", err, err_code);
    end
    check_two_good_writes("good");
  endtask

  task automatic test_bad_checksum();
    logic [7:0] f [0:7];
    f = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
    clear_writes();
    for (int i = 0; i < 8; i++) send_byte(f[i]);
    total++;
    if (err !== 1'b1 || err_code !== 2'd1 || cpu_run !== 1'b0) begin
      bad++; $display("FAIL csum_err got err=%b code=%0d run=%b want 1/1/0", err, err_code, cpu_run);
    end
    total++;
    if (wa.size() !== 2) begin
      bad++; $display("FAIL csum_writes got=%0d want=2", wa.size());
    end
    clear_writes();
    send_byte(8'hA5);
    total++;
    if (err !== 1'b0 || err_code !== 2'd0 || busy !== 1'b1) begin
      bad++; $display("FAIL csum_clear got err=%b code=%0d busy=%b want 0/0/1", err, err_code, busy);
    end
    f[7] = 8'h40;
    for (int i = 1; i < 8; i++) send_byte(f[i]);
    total++;
    if (cpu_run !== 1'b1 || err !== 1'b0) begin
      bad++; $display("FAIL csum_recover got run=%b err=%b want 1/0", cpu_run, err);
    end
    check_two_good_writes("recover");
  endtask

  task automatic test_length_bound();
    logic [7:0]  sum;
    logic [15:0] w;
    int          wrong;
    clear_writes();
    send_byte(8'hA5); send_byte(8'h04); send_byte(8'h01);
    total++;
    if (err !== 1'b1 || err_code !== 2'd2 || busy !== 1'b0) begin
      bad++; $display("FAIL len_over got err=%b code=%0d busy=%b want 1/2/0", err, err_code, busy);
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (wa.size() !== 0) begin
      bad++; $display("FAIL len_over_writes got=%0d want=0", wa.size());
    end
    // Zero-length frame goes straight to the checksum byte.
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    total++;
    if (cpu_run !== 1'b1 || wa.size() !== 0) begin
      bad++; $display("FAIL len_zero got run=%b writes=%0d want 1/0", cpu_run, wa.size());
    end
    // Full-depth load: word i holds value i.
    sum = 8'h04;
    send_byte(8'hA5); send_byte(8'h04); send_byte(8'h00);
    for (int i = 0; i < 1024; i++) begin
      w = 16'(i);
      send_byte(w[15:8]);
      send_byte(w[7:0]);
      sum = sum + w[15:8] + w[7:0];
    end
    send_byte(8'(8'h00 - sum));
    total++;
    if (cpu_run !== 1'b1 || err !== 1'b0) begin
      bad++; $display("FAIL len_full_run got run=%b err=%b want 1/0", cpu_run, err);
    end
    total++;
    if (wa.size() !== 1024) begin
      bad++; $display("FAIL len_full_count got=%0d want=1024", wa.size());
    end else begin
      total++;
      if (wa[1023] !== 10'h3FF) begin
        bad++; $display("FAIL len_full_last_addr got=%h want=3ff", wa[1023]);
      end
      wrong = 0;
      for (int i = 0; i < 1024; i++) begin
        w = 16'(i);
        if (wa[i] !== w[9:0] || wd[i] !== w) wrong++;
      end
      total++;
      if (wrong !== 0) begin
        bad++; $display("FAIL len_full_data got %0d wrong words want 0", wrong);
      end
    end
  endtask

  task automatic test_reload();
    clear_writes();
    send_byte(8'h12);
    total++;
    if (cpu_run !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL run_discard got run=%b busy=%b want 1/0", cpu_run, busy);
    end
    send_byte(8'hA5);
    total++;
    if (cpu_run !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL reload_drop got run=%b busy=%b want 0/1", cpu_run, busy);
    end
    send_byte(8'h00); send_byte(8'h01); send_byte(8'hBE); send_byte(8'hEF); send_byte(8'h52);
    total++;
    if (cpu_run !== 1'b1 || err !== 1'b0) begin
      bad++; $display("FAIL reload_run got run=%b err=%b want 1/0", cpu_run, err);
    end
    total++;
    if (wa.size() !== 1) begin
      bad++; $display("FAIL reload_count got=%0d want=1", wa.size());
    end else begin
      total++;
      if (wa[0] !== 10'h000 || wd[0] !== 16'hBEEF) begin
        bad++; $display("FAIL reload_write got=(%h,%h) want=(000,beef)", wa[0], wd[0]);
      end
    end
  endtask

  task automatic test_timeout();
    int seen;
    clear_writes();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01); send_byte(8'h12);
    seen = 0;
    for (int k = 1; k <= 24; k++) begin
      @(posedge clk);
      #1;
      if (seen == 0 && err === 1'b1) seen = k;
    end
    total++;
    if (seen !== 16) begin
      bad++; $display("FAIL timeout_cycles got=%0d want=16", seen);
    end
    total++;
    if (err_code !== 2'd3 || busy !== 1'b0 || cpu_run !== 1'b0) begin
      bad++; $display("FAIL timeout_state got code=%0d busy=%b run=%b want 3/0/0", err_code, busy, cpu_run);
    end
    total++;
    if (wa.size() !== 0) begin
      bad++; $display("FAIL timeout_writes got=%0d want=0", wa.size());
    end
  endtask

  task automatic test_reset_mid_data();
    logic [7:0] f [0:7];
    f = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02); send_byte(8'h12);
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL mid_busy got=%b want=1", busy);
    end
    hard_rst = 1'b1;
    #1;
    total++;
    if ({in_ready, wr_en, wr_addr, wr_data, cpu_run, busy, err, err_code} !==
        {1'b1, 1'b0, 10'h0, 16'h0, 1'b0, 1'b0, 1'b0, 2'd0}) begin
      bad++; $display("FAIL mid_reset got rdy=%b we=%b a=%h d=%h run=%b busy=%b err=%b code=%0d",
                      in_ready, wr_en, wr_addr, wr_data, cpu_run, busy, err, err_code);
    end
    @(negedge clk);
    hard_rst = 1'b0;
    clear_writes();
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) send_byte(f[i]);
    total++;
    if (cpu_run !== 1'b1 || err !== 1'b0) begin
      bad++; $display("FAIL after_reset_run got run=%b err=%b want 1/0", cpu_run, err);
    end
    check_two_good_writes("after_reset");
  endtask

  initial begin
    test_reset();
    test_good_load();
    test_bad_checksum();
    test_length_bound();
    test_reload();
    test_timeout();
    test_reset_mid_data();
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
